// File: rtl/directory_controller.sv
// directory_controller: two-cache coherence directory.
// It serves one request at a time. For each request it looks up the
// directory entry, sends any snoop to the other cache, then any memory
// operation, updates the entry, and returns a one-cycle response.
module directory_controller #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [IDX_W-1:0] req1_idx,
  output logic             req1_ready,
  input  logic             req2_valid,
  input  logic [2:0]       req2_op,
  input  logic [IDX_W-1:0] req2_idx,
  output logic             req2_ready,
  output logic             snp_valid,
  output logic [1:0]       snp_dest,
  output logic [2:0]       snp_op,
  output logic [IDX_W-1:0] snp_idx,
  input  logic             snp_ack,
  output logic             mem_valid,
  output logic             mem_wr,
  output logic [IDX_W-1:0] mem_idx,
  input  logic             mem_ack,
  output logic             rsp_valid,
  output logic [1:0]       rsp_dest,
  output logic [2:0]       rsp_op,
  output logic [1:0]       rsp_state
);

  localparam int ENTRIES = 1 << IDX_W;

  localparam logic [2:0] OP_REPLY = 3'd2;
  localparam logic [2:0] OP_RD    = 3'd3;
  localparam logic [2:0] OP_WR    = 3'd4;
  localparam logic [2:0] OP_INV   = 3'd5;
  localparam logic [2:0] OP_UPD   = 3'd6;
  localparam logic [2:0] OP_RWITM = 3'd7;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_M = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    SNOOP  = 3'd2,
    MEM    = 3'd3,
    UPDATE = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Entry layout: [1:0] cache 1 state, [3:2] cache 2 state.
  logic [3:0]       dir_mem [ENTRIES];

  // ptr = 0 gives cache 1 priority on a tie; src_q = 0 means cache 1.
  logic             ptr;
  logic             src_q;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] idx_q;

  logic             grant_any;
  logic             grant_sel;

  logic [3:0]       cur_ent;
  logic [1:0]       src_st;
  logic [1:0]       oth_st;
  logic             is_rd;
  logic             is_wr;
  logic             is_inv;
  logic             is_upd;
  logic             is_rwitm;
  logic             legal_op;
  logic             need_snp;
  logic [2:0]       snp_code;
  logic             mem_write_need;
  logic             mem_read_need;
  logic             need_mem;
  logic [1:0]       new_src;
  logic [1:0]       new_oth;
  logic [3:0]       new_ent;

  // Round-robin arbiter: a sole requester wins, on a tie the pointer decides.
  always_comb begin
    grant_any = req1_valid | req2_valid;
    grant_sel = (req1_valid & req2_valid) ? ptr : req2_valid;
  end

  // Decode of the captured request against its entry. The entry cannot change
  // until UPDATE writes it, so it is read straight from the array here.
  always_comb begin
    cur_ent  = dir_mem[idx_q];
    src_st   = src_q ? cur_ent[3:2] : cur_ent[1:0];
    oth_st   = src_q ? cur_ent[1:0] : cur_ent[3:2];
    is_rd    = (op_q == OP_RD);
    is_wr    = (op_q == OP_WR);
    is_inv   = (op_q == OP_INV);
    is_upd   = (op_q == OP_UPD);
    is_rwitm = (op_q == OP_RWITM);
    legal_op = (op_q >= OP_RD);

    need_snp = (is_rd & (oth_st == ST_M)) |
               ((is_upd | is_rwitm) & (oth_st != ST_I));
    snp_code = is_rd ? OP_RD : OP_INV;

    // Only RD/RWITM write back a modified line from the other cache;
    // UPD and INV never touch memory even if the other copy was M.
    mem_write_need = is_wr | ((is_rd | is_rwitm) & (oth_st == ST_M));
    mem_read_need  = (is_rd | is_rwitm) & (oth_st != ST_M);
    need_mem       = mem_write_need | mem_read_need;

    new_src = src_st;
    new_oth = oth_st;
    if (is_rd) begin
      new_src = ST_S;
      if (oth_st == ST_M) begin
        new_oth = ST_S;
      end
    end else if (is_upd | is_rwitm) begin
      new_src = ST_M;
      new_oth = ST_I;
    end else if (is_wr | is_inv) begin
      new_src = ST_I;
    end
    new_ent = src_q ? {new_src, new_oth} : {new_oth, new_src};
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic for the request sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (need_snp) begin
          state_nxt = SNOOP;
        end else if (need_mem) begin
          state_nxt = MEM;
        end else begin
          state_nxt = UPDATE;
        end
      end
      SNOOP: begin
        if (snp_ack) begin
          state_nxt = need_mem ? MEM : UPDATE;
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs per state; ready is also gated by rst so it stays low in reset.
  always_comb begin
    req1_ready = 1'b0;
    req2_ready = 1'b0;
    snp_valid  = 1'b0;
    snp_dest   = 2'd0;
    snp_op     = 3'd0;
    snp_idx    = '0;
    mem_valid  = 1'b0;
    mem_wr     = 1'b0;
    mem_idx    = '0;
    rsp_valid  = 1'b0;
    rsp_dest   = 2'd0;
    rsp_op     = 3'd0;
    rsp_state  = 2'd0;
    case (state)
      IDLE: begin
        req1_ready = grant_any & ~grant_sel & ~rst;
        req2_ready = grant_any & grant_sel & ~rst;
      end
      SNOOP: begin
        snp_valid = 1'b1;
        snp_dest  = src_q ? 2'd1 : 2'd2;
        snp_op    = snp_code;
        snp_idx   = idx_q;
      end
      MEM: begin
        mem_valid = 1'b1;
        mem_wr    = mem_write_need;
        mem_idx   = idx_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_dest  = src_q ? 2'd2 : 2'd1;
        rsp_op    = legal_op ? OP_REPLY : 3'd0;
        rsp_state = src_st;
      end
      default: begin
      end
    endcase
  end

  // Request capture, arbiter pointer and the single-cycle directory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= 1'b0;
      src_q <= 1'b0;
      op_q  <= 3'd0;
      idx_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        dir_mem[i] <= 4'd0;
      end
    end else begin
      if (state == IDLE && grant_any) begin
        src_q <= grant_sel;
        op_q  <= grant_sel ? req2_op : req1_op;
        idx_q <= grant_sel ? req2_idx : req1_idx;
        ptr   <= ~grant_sel;
      end
      if (state == UPDATE && legal_op) begin
        dir_mem[idx_q] <= new_ent;
      end
    end
  end

endmodule

// File: tb/tb_directory_controller.sv
// tb_directory_controller: randomized scoreboard bench for directory_controller.
// Drivers push the expected snoop/memory/response of each granted request into
// a queue; an independent monitor checks whatever the DUT presents.
module tb_directory_controller;

  localparam int IDX_W = 4;
  localparam int N     = 1 << IDX_W;

  localparam int RD    = 3;
  localparam int WR    = 4;
  localparam int INV   = 5;
  localparam int UPD   = 6;
  localparam int RWITM = 7;

  localparam int I_ST = 0;
  localparam int S_ST = 1;
  localparam int M_ST = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req1_valid = 1'b0;
  logic [2:0]       req1_op = 3'd0;
  logic [IDX_W-1:0] req1_idx = '0;
  logic             req1_ready;
  logic             req2_valid = 1'b0;
  logic [2:0]       req2_op = 3'd0;
  logic [IDX_W-1:0] req2_idx = '0;
  logic             req2_ready;
  logic             snp_valid;
  logic [1:0]       snp_dest;
  logic [2:0]       snp_op;
  logic [IDX_W-1:0] snp_idx;
  logic             snp_ack = 1'b0;
  logic             mem_valid;
  logic             mem_wr;
  logic [IDX_W-1:0] mem_idx;
  logic             mem_ack = 1'b0;
  logic             rsp_valid;
  logic [1:0]       rsp_dest;
  logic [2:0]       rsp_op;
  logic [1:0]       rsp_state;

  directory_controller #(.IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_idx   (req1_idx),
    .req1_ready (req1_ready),
    .req2_valid (req2_valid),
    .req2_op    (req2_op),
    .req2_idx   (req2_idx),
    .req2_ready (req2_ready),
    .snp_valid  (snp_valid),
    .snp_dest   (snp_dest),
    .snp_op     (snp_op),
    .snp_idx    (snp_idx),
    .snp_ack    (snp_ack),
    .mem_valid  (mem_valid),
    .mem_wr     (mem_wr),
    .mem_idx    (mem_idx),
    .mem_ack    (mem_ack),
    .rsp_valid  (rsp_valid),
    .rsp_dest   (rsp_dest),
    .rsp_op     (rsp_op),
    .rsp_state  (rsp_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int src;
    int op;
    int idx;
    int has_snp;
    int snp_op;
    int has_mem;
    int mem_wr;
    int rsp_op;
    int rsp_state;
    int accept_cycle;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int dir_model [2][N];
  int arb_ptr   = 1;
  int checks    = 0;
  int failures  = 0;
  int cycle     = 0;
  bit hold_acks = 1'b0;
  bit busy      = 1'b0;
  bit snp_seen  = 1'b0;
  bit mem_seen  = 1'b0;

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic void clearModel();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < N; i++) begin
        dir_model[c][i] = I_ST;
      end
    end
    arb_ptr = 1;
  endfunction

  // Reference protocol model: returns the expected behaviour of one request
  // and applies its effect to the directory model.
  function automatic exp_t grantModel(input int c, input int op, input int idx);
    exp_t e;
    int me;
    int other;
    e       = '0;
    e.src   = c;
    e.op    = op;
    e.idx   = idx;
    me      = dir_model[c-1][idx];
    other   = dir_model[2-c][idx];
    if (op < RD) begin
      e.rsp_op    = 0;
      e.rsp_state = me;
      return e;
    end
    if (op == RD && other == M_ST) begin
      e.has_snp = 1;
      e.snp_op  = RD;
    end
    if ((op == UPD || op == RWITM) && other != I_ST) begin
      e.has_snp = 1;
      e.snp_op  = INV;
    end
    if (op == WR) begin
      e.has_mem = 1;
      e.mem_wr  = 1;
    end
    if (op == RD || op == RWITM) begin
      e.has_mem = 1;
      e.mem_wr  = (other == M_ST) ? 1 : 0;
    end
    case (op)
      RD: begin
        me = S_ST;
        if (other == M_ST) other = S_ST;
      end
      UPD, RWITM: begin
        me    = M_ST;
        other = I_ST;
      end
      default: me = I_ST;
    endcase
    dir_model[c-1][idx] = me;
    dir_model[2-c][idx] = other;
    e.rsp_op    = 2;
    e.rsp_state = me;
    return e;
  endfunction

  // Raise a request from cache c and hold it until granted.
  task automatic applyStimulus(input int c, input int op, input int idx);
    bit   granted;
    int   winner;
    exp_t e;
    granted = 1'b0;
    @(posedge clk);
    #1;
    if (c == 1) begin
      req1_valid = 1'b1;
      req1_op    = 3'(op);
      req1_idx   = IDX_W'(idx);
    end else begin
      req2_valid = 1'b1;
      req2_op    = 3'(op);
      req2_idx   = IDX_W'(idx);
    end
    for (int n = 0; n < 400 && !granted; n++) begin
      @(negedge clk);
      if ((c == 1 && req1_ready) || (c == 2 && req2_ready)) begin
        winner = (req1_valid && req2_valid) ? arb_ptr : (req1_valid ? 1 : 2);
        checkOutput($sformatf("arb_grant_cache%0d", c), c, winner);
        arb_ptr = 3 - c;
        e = grantModel(c, op, idx);
        e.accept_cycle = cycle;
        exp_q.push_back(e);
        granted = 1'b1;
      end
    end
    if (!granted) checkOutput($sformatf("ready_timeout_cache%0d", c), 0, 1);
    @(posedge clk);
    #1;
    if (c == 1) req1_valid = 1'b0;
    else        req2_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput(name, int'({req1_ready, req2_ready, snp_valid, snp_dest, snp_op, snp_idx,
                            mem_valid, mem_wr, mem_idx, rsp_valid, rsp_dest, rsp_op, rsp_state}), 0);
  endtask

  // Snoop and memory responders with random latency and stray acks while idle.
  always @(posedge clk) begin
    #1;
    if (rst || hold_acks) begin
      snp_ack = 1'b0;
      mem_ack = 1'b0;
    end else begin
      snp_ack = snp_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_ack = mem_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    end
  end

  // Monitor: compares every presented snoop, memory op and response with the queue head.
  always @(negedge clk) begin
    if (rst) begin
      busy     = 1'b0;
      snp_seen = 1'b0;
      mem_seen = 1'b0;
    end else begin
      if (req1_ready || req2_ready) begin
        checkOutput("ready_only_when_idle", int'(busy || (req1_ready && req2_ready)), 0);
        busy = 1'b1;
      end
      if (snp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("snoop_without_request", 1, 0);
        end else begin
          mon_e = exp_q[0];
          checkOutput("snoop_expected", 1, mon_e.has_snp);
          checkOutput("snp_dest", int'(snp_dest), 3 - mon_e.src);
          checkOutput("snp_op", int'(snp_op), mon_e.snp_op);
          checkOutput("snp_idx", int'(snp_idx), mon_e.idx);
          checkOutput("snoop_before_mem", int'(mem_seen), 0);
        end
        snp_seen = 1'b1;
      end
      if (mem_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("mem_without_request", 1, 0);
        end else begin
          mon_e = exp_q[0];
          checkOutput("mem_expected", 1, mon_e.has_mem);
          checkOutput("mem_wr", int'(mem_wr), mon_e.mem_wr);
          checkOutput("mem_idx", int'(mem_idx), mon_e.idx);
        end
        mem_seen = 1'b1;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_without_request", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_dest", int'(rsp_dest), mon_e.src);
          checkOutput("rsp_op", int'(rsp_op), mon_e.rsp_op);
          checkOutput($sformatf("rsp_state_idx%0d", mon_e.idx), int'(rsp_state), mon_e.rsp_state);
          checkOutput("snoop_issued", int'(snp_seen), mon_e.has_snp);
          checkOutput("mem_issued", int'(mem_seen), mon_e.has_mem);
          if (mon_e.has_snp == 0 && mon_e.has_mem == 0)
            checkOutput("min_latency", cycle - mon_e.accept_cycle, 3);
        end
        busy     = 1'b0;
        snp_seen = 1'b0;
        mem_seen = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int mode;
    int op1, op2, idx1, idx2;

    clearModel();

    // Reset with both caches requesting: everything must stay quiet.
    req1_valid = 1'b1;
    req2_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_outputs");
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req2_valid = 1'b0;
    rst        = 1'b0;

    // Simultaneous pairs from reset: cache 1 first, and again on the next pair.
    fork
      applyStimulus(1, 0, 0);
      applyStimulus(2, 0, 1);
    join
    fork
      applyStimulus(1, 1, 2);
      applyStimulus(2, 2, 3);
    join
    waitIdle();

    // Read miss on an idle line.
    applyStimulus(1, RD, 3);
    applyStimulus(1, 0, 3);
    applyStimulus(2, 0, 3);

    // Read of a line modified in cache 2: downgrade snoop, then write-back.
    applyStimulus(2, RWITM, 5);
    applyStimulus(1, RD, 5);
    applyStimulus(1, 0, 5);
    applyStimulus(2, 0, 5);

    // Upgrade from shared: invalidate snoop, no memory op.
    applyStimulus(1, RD, 7);
    applyStimulus(2, RD, 7);
    applyStimulus(2, UPD, 7);
    applyStimulus(1, 0, 7);

    // Invalidate of a shared line takes the minimum latency.
    applyStimulus(1, RD, 0);
    applyStimulus(1, INV, 0);
    applyStimulus(1, 0, 0);
    waitIdle();

    // Reset while a snoop is outstanding.
    applyStimulus(2, RWITM, 9);
    waitIdle();
    hold_acks = 1'b1;
    applyStimulus(1, RD, 9);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (snp_valid) found = 1'b1;
    end
    checkOutput("snoop_reached_before_reset", int'(found), 1);
    #1;
    rst = 1'b1;
    #1;
    checkResetOutputs("abort_outputs");
    exp_q.delete();
    clearModel();
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", int'(rsp_valid), 0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    hold_acks = 1'b0;
    fork
      applyStimulus(1, 0, 9);
      applyStimulus(2, 1, 9);
    join
    waitIdle();

    // Randomized traffic, mostly on a few lines to force conflicts.
    for (int t = 0; t < 200; t++) begin
      mode = $urandom_range(0, 3);
      op1  = $urandom_range(0, 7);
      op2  = $urandom_range(0, 7);
      idx1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 3);
      idx2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 3);
      if (mode == 0) begin
        fork
          applyStimulus(1, op1, idx1);
          applyStimulus(2, op2, idx2);
        join
      end else begin
        applyStimulus($urandom_range(1, 2), op1, idx1);
      end
    end
    waitIdle();

    // Read back every line from both caches.
    for (int i = 0; i < N; i++) begin
      applyStimulus(1, 0, i);
      applyStimulus(2, 0, i);
    end
    waitIdle();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
